// File: rtl/bus_cycle_sequencer.sv
// Master-side sequencer for an 8088-style peripheral bus. It arbitrates the
// local requesters round-robin and runs one T1..T4 bus cycle per grant, with
// registered strobes, a one-hot chip select decode and a tri-stated data bus.
//
// Requester handshake: a requester raises req[i] together with stable
// req_we/req_io/req_addr/req_wdata and holds req[i] high until done[i] pulses
// for one clock in T4. The request fields are latched when the grant is
// issued, so changes on the request side after that point do not affect the
// cycle in flight. A request that drops early still completes its cycle.
module bus_cycle_sequencer #(
  parameter int NREQ   = 2,
  parameter int ADDR_W = 20,
  parameter int DATA_W = 8
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ-1:0]          req_we,
  input  logic [NREQ-1:0]          req_io,
  input  logic [NREQ*ADDR_W-1:0]   req_addr,
  input  logic [NREQ*DATA_W-1:0]   req_wdata,
  output logic [NREQ-1:0]          gnt,
  output logic [NREQ-1:0]          done,
  output logic [DATA_W-1:0]        rdata,
  output logic                     ALE,
  output logic                     RD,
  output logic                     WR,
  output logic                     IOM,
  output logic [3:0]               CS,
  output logic [ADDR_W-1:0]        Address,
  inout  wire  [DATA_W-1:0]        Data,
  output logic [2:0]               o_dbg_state
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_T1   = 3'd1,
    S_T2   = 3'd2,
    S_T3   = 3'd3,
    S_T4   = 3'd4
  } state_t;

  state_t              r_state;
  logic [PTR_W-1:0]    r_ptr;
  logic [PTR_W-1:0]    r_owner;
  logic                r_we;
  logic [DATA_W-1:0]   r_wdata;
  logic                r_data_oe;
  logic [NREQ-1:0]     r_gnt;
  logic [NREQ-1:0]     r_done;
  logic [DATA_W-1:0]   r_rdata;
  logic                r_ale;
  logic                r_rd;
  logic                r_wr;
  logic                r_iom;
  logic [3:0]          r_cs;
  logic [ADDR_W-1:0]   r_address;

  logic                w_found;
  logic [PTR_W-1:0]    w_sel;
  logic [PTR_W-1:0]    w_next_ptr;
  logic [ADDR_W-1:0]   w_addr;
  logic [DATA_W-1:0]   w_wdata;
  int                  w_idx;

  // Round-robin search: first active request at or after the pointer, wrapping.
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    w_idx   = 0;
    for (int i = 0; i < NREQ; i++) begin
      w_idx = int'(r_ptr) + i;
      if (w_idx >= NREQ) w_idx = w_idx - NREQ;
      if (!w_found && req[PTR_W'(w_idx)]) begin
        w_found = 1'b1;
        w_sel   = PTR_W'(w_idx);
      end
    end
  end

  assign w_addr     = req_addr[w_sel*ADDR_W +: ADDR_W];
  assign w_wdata    = req_wdata[w_sel*DATA_W +: DATA_W];
  assign w_next_ptr = (r_owner == PTR_W'(NREQ - 1)) ? '0 : r_owner + 1'b1;

  // Bus cycle FSM; every bus-facing output is a register updated here.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state   <= S_IDLE;
      r_ptr     <= '0;
      r_owner   <= '0;
      r_we      <= 1'b0;
      r_wdata   <= '0;
      r_data_oe <= 1'b0;
      r_gnt     <= '0;
      r_done    <= '0;
      r_rdata   <= '0;
      r_ale     <= 1'b0;
      r_rd      <= 1'b1;
      r_wr      <= 1'b1;
      r_iom     <= 1'b0;
      r_cs      <= 4'b0000;
      r_address <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= '0;
          if (w_found) begin
            r_owner   <= w_sel;
            r_we      <= req_we[w_sel];
            r_wdata   <= w_wdata;
            r_gnt     <= NREQ'(1) << w_sel;
            r_ale     <= 1'b1;
            r_address <= w_addr;
            r_iom     <= req_io[w_sel];
            r_cs      <= 4'b0001 << {req_io[w_sel], w_addr[ADDR_W-1]};
            r_state   <= S_T1;
          end
        end
        S_T1: begin
          r_ale     <= 1'b0;
          r_rd      <= r_we;
          r_wr      <= ~r_we;
          r_data_oe <= r_we;
          r_state   <= S_T2;
        end
        S_T2: begin
          r_state <= S_T3;
        end
        S_T3: begin
          if (!r_we) r_rdata <= Data;
          r_rd      <= 1'b1;
          r_wr      <= 1'b1;
          r_cs      <= 4'b0000;
          r_data_oe <= 1'b0;
          r_done    <= NREQ'(1) << r_owner;
          r_ptr     <= w_next_ptr;
          r_state   <= S_T4;
        end
        S_T4: begin
          r_done  <= '0;
          r_gnt   <= '0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign Data        = r_data_oe ? r_wdata : 'z;
  assign gnt         = r_gnt;
  assign done        = r_done;
  assign rdata       = r_rdata;
  assign ALE         = r_ale;
  assign RD          = r_rd;
  assign WR          = r_wr;
  assign IOM         = r_iom;
  assign CS          = r_cs;
  assign Address     = r_address;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_bus_cycle_sequencer.sv
// Bench for bus_cycle_sequencer: a memory/IO slave model on the bus, request
// counters per requester, and a negedge monitor that walks each bus cycle
// against the expected transaction queue.
module tb_bus_cycle_sequencer;

  localparam int NREQ   = 2;
  localparam int ADDR_W = 20;
  localparam int DATA_W = 8;
  localparam int RW     = 48;

  // clock / reset
  logic CLK = 1'b0;
  logic RESET = 1'b1;
  always #5 CLK = ~CLK;

  logic [NREQ-1:0]        req;
  logic [NREQ-1:0]        req_we = '0;
  logic [NREQ-1:0]        req_io = '0;
  logic [NREQ*ADDR_W-1:0] req_addr = '0;
  logic [NREQ*DATA_W-1:0] req_wdata = '0;
  logic [NREQ-1:0]        gnt;
  logic [NREQ-1:0]        done;
  logic [DATA_W-1:0]      rdata;
  logic                   ALE, RD, WR, IOM;
  logic [3:0]             CS;
  logic [ADDR_W-1:0]      Address;
  wire  [DATA_W-1:0]      bus_data;
  logic [2:0]             dbg_state;

  bus_cycle_sequencer #(.NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .CLK(CLK), .RESET(RESET), .req(req), .req_we(req_we), .req_io(req_io),
    .req_addr(req_addr), .req_wdata(req_wdata), .gnt(gnt), .done(done),
    .rdata(rdata), .ALE(ALE), .RD(RD), .WR(WR), .IOM(IOM), .CS(CS),
    .Address(Address), .Data(bus_data), .o_dbg_state(dbg_state)
  );

  // slave model: drives read data while RD is low, stores write data while WR is low
  logic [7:0] slv_mem [256];
  logic [7:0] ref_mem [256];
  logic [7:0] zz8 = 'z;
  wire  [7:0] slv_idx = {IOM, Address[19], Address[5:0]};
  assign bus_data = (!RD) ? slv_mem[slv_idx] : 8'hzz;
  always @(negedge CLK) if (!RESET && !WR) slv_mem[slv_idx] <= bus_data;

  // requester bookkeeping: req[i] is high while issued work is outstanding
  int issued [NREQ];
  int served [NREQ];
  int cancel [NREQ];
  bit drop   [NREQ];
  always_comb begin
    req = '0;
    for (int i = 0; i < NREQ; i++)
      req[i] = !drop[i] && (issued[i] != served[i] + cancel[i]);
  end

  // scoreboard
  logic [RW-1:0] exp_q[$];
  int n_total = 0;
  int n_bad = 0;
  int model_ptr = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] mem_idx(input bit io, input logic [19:0] a);
    return {io, a[19], a[5:0]};
  endfunction

  // record: [46:44] owner, [43] we, [42] io, [41:38] cs, [37:30] wdata, [29:22] rdata, [19:0] addr
  task automatic push_exp(input int i);
    logic [RW-1:0] r;
    logic [19:0] a;
    logic [7:0] wd, rd, ix;
    logic [3:0] cs;
    a  = req_addr[i*ADDR_W +: ADDR_W];
    wd = req_wdata[i*DATA_W +: DATA_W];
    ix = mem_idx(req_io[i], a);
    rd = ref_mem[ix];
    if (req_we[i]) ref_mem[ix] = wd;
    cs = 4'b0001 << {req_io[i], a[19]};
    r = '0;
    r[46:44] = 3'(i);
    r[43] = req_we[i];
    r[42] = req_io[i];
    r[41:38] = cs;
    r[37:30] = wd;
    r[29:22] = rd;
    r[19:0] = a;
    exp_q.push_back(r);
    model_ptr = (i + 1) % NREQ;
  endtask

  task automatic set_req(input int i, input bit we, input bit io, input logic [19:0] a, input logic [7:0] wd);
    req_we[i] = we;
    req_io[i] = io;
    req_addr[i*ADDR_W +: ADDR_W] = a;
    req_wdata[i*DATA_W +: DATA_W] = wd;
  endtask

  task automatic issue(input int i, input bit we, input bit io, input logic [19:0] a, input logic [7:0] wd);
    set_req(i, we, io, a, wd);
    push_exp(i);
    issued[i]++;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge CLK);
      n++;
    end
    #1;
    check_eq(tag, exp_q.size(), 0);
    repeat (2) @(negedge CLK);
    #1;
  endtask

  // monitor: phase 0 = idle, 1..4 = T1..T4 as seen from the bus
  int mon_phase = 0;
  int cyc = 0;
  int last_t1 = 0;
  bit b2b_chk = 0;
  bit cur_valid = 0;
  logic [RW-1:0] cur = '0;
  always @(posedge CLK) cyc++;

  always @(negedge CLK) begin
    logic [1:0] own1h;
    logic we;
    if (RESET) begin
      mon_phase = 0;
      cur_valid = 0;
    end else begin
      if (mon_phase == 0 && gnt != 0) mon_phase = 1;
      else if (mon_phase == 4) mon_phase = 0;
      else if (mon_phase != 0) mon_phase = mon_phase + 1;
      if (mon_phase == 1) begin
        if (exp_q.size() == 0) begin
          check_eq("spurious_cycle", gnt, 0);
          cur_valid = 0;
        end else begin
          cur = exp_q[0];
          cur_valid = 1;
        end
        if (b2b_chk && last_t1 != 0) check_eq("b2b_spacing", cyc - last_t1, 5);
        last_t1 = b2b_chk ? cyc : 0;
      end
      own1h = 2'b01 << cur[46:44];
      we = cur[43];
      case (mon_phase)
        0: begin
          check_eq("idle_gnt", gnt, 0);
          check_eq("idle_done", done, 0);
          check_eq("idle_ale", ALE, 0);
          check_eq("idle_strobes", {RD, WR}, 2'b11);
          check_eq("idle_cs", CS, 0);
          check_eq("idle_state", dbg_state, 0);
        end
        1: if (cur_valid) begin
          check_eq("t1_gnt", gnt, own1h);
          check_eq("t1_ale", ALE, 1);
          check_eq("t1_strobes", {RD, WR}, 2'b11);
          check_eq("t1_cs", CS, cur[41:38]);
          check_eq("t1_iom", IOM, cur[42]);
          check_eq("t1_addr", Address, cur[19:0]);
          check_eq("t1_done", done, 0);
          check_eq("t1_data_z", bus_data, zz8);
          check_eq("t1_state", dbg_state, 1);
        end
        2, 3: if (cur_valid) begin
          check_eq("t23_gnt", gnt, own1h);
          check_eq("t23_ale", ALE, 0);
          check_eq("t23_rd", RD, we);
          check_eq("t23_wr", WR, !we);
          check_eq("t23_cs", CS, cur[41:38]);
          check_eq("t23_iom", IOM, cur[42]);
          check_eq("t23_addr", Address, cur[19:0]);
          check_eq("t23_done", done, 0);
          check_eq("t23_state", dbg_state, 3'(mon_phase));
          if (we) check_eq("t23_wdata", bus_data, cur[37:30]);
        end
        4: if (cur_valid) begin
          check_eq("t4_done", done, own1h);
          check_eq("t4_strobes", {RD, WR}, 2'b11);
          check_eq("t4_cs", CS, 0);
          check_eq("t4_data_z", bus_data, zz8);
          check_eq("t4_state", dbg_state, 4);
          if (!we) check_eq("t4_rdata", rdata, cur[29:22]);
          served[cur[46:44]]++;
          void'(exp_q.pop_front());
          cur_valid = 0;
        end
        default: ;
      endcase
    end
  end

  task automatic wait_phase(input int p, input string tag);
    int n;
    n = 0;
    while (mon_phase != p && n < 60) begin
      @(negedge CLK);
      #1;
      n++;
    end
    check_eq(tag, mon_phase, p);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_gnt"}, gnt, 0);
    check_eq({tag, "_done"}, done, 0);
    check_eq({tag, "_ale"}, ALE, 0);
    check_eq({tag, "_strobes"}, {RD, WR}, 2'b11);
    check_eq({tag, "_iom"}, IOM, 0);
    check_eq({tag, "_cs"}, CS, 0);
    check_eq({tag, "_addr"}, Address, 0);
    check_eq({tag, "_rdata"}, rdata, 0);
    check_eq({tag, "_data_z"}, bus_data, zz8);
    check_eq({tag, "_state"}, dbg_state, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) begin
      slv_mem[i] = 8'(i) ^ 8'h5A;
      ref_mem[i] = 8'(i) ^ 8'h5A;
    end
    for (int i = 0; i < NREQ; i++) begin
      issued[i] = 0; served[i] = 0; cancel[i] = 0; drop[i] = 0;
    end
    repeat (2) @(negedge CLK);
    #1;
    check_reset_outputs("reset");
    @(negedge CLK);
    RESET = 1'b0;
    #1;

    // 1: read from memory by requester 0
    issue(0, 1'b0, 1'b0, 20'h00010, 8'h00);
    drain("t1_drain");

    // 2: IO write by requester 1, then read the same location back
    issue(1, 1'b1, 1'b1, 20'h80005, 8'hA5);
    drain("t2w_drain");
    issue(1, 1'b0, 1'b1, 20'h80005, 8'h00);
    drain("t2r_drain");
    check_eq("t2_readback", rdata, 8'hA5);

    // 3: both requesters held for six transactions, back to back
    b2b_chk = 1;
    set_req(0, 1'b0, 1'b0, 20'h00020, 8'h00);
    set_req(1, 1'b0, 1'b1, 20'h80021, 8'h00);
    for (int k = 0; k < 6; k++) push_exp(model_ptr);
    issued[0] += 3;
    issued[1] += 3;
    drain("t3_drain");
    b2b_chk = 0;

    // 5: decode sweep of io x addr[19] with random low address bits
    for (int k = 0; k < 4; k++) begin
      logic [19:0] a;
      a = {k[0], 13'h0, 6'($urandom_range(0, 63))};
      issue(0, 1'b0, k[1], a, 8'h00);
      drain("t5_drain");
    end

    // 4: reset in T2 of a write by requester 1, then both request
    issue(1, 1'b1, 1'b0, 20'h0003F, 8'($urandom_range(0, 255)));
    wait_phase(2, "t4_reach_t2");
    #2;
    RESET = 1'b1;
    #1;
    check_reset_outputs("midreset");
    void'(exp_q.pop_front());
    cancel[1]++;
    repeat (2) @(negedge CLK);
    RESET = 1'b0;
    model_ptr = 0;
    #1;
    set_req(0, 1'b0, 1'b0, 20'h00030, 8'h00);
    set_req(1, 1'b0, 1'b0, 20'h80031, 8'h00);
    push_exp(model_ptr);
    push_exp(model_ptr);
    issued[0]++;
    issued[1]++;
    drain("t4_drain");

    // 6: requester 0 drops its request during T2
    issue(0, 1'b0, 1'b1, 20'h0002A, 8'h00);
    wait_phase(2, "t6_reach_t2");
    drop[0] = 1;
    drain("t6_drain");
    for (int k = 0; k < 6; k++) begin
      @(negedge CLK);
      #1;
      check_eq("t6_stay_idle", dbg_state, 0);
    end
    drop[0] = 0;

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
